// File: rtl/comet_pkg.sv
// Shared sprite-subsystem definitions: RAM geometry, arbiter state encoding and a
// saturating-increment helper. Imported by the arbiter, its CPU-bus interface, the
// sprite engine and the bench.
package comet_pkg;

  localparam int unsigned SPR_RAM_AW = 7;
  localparam int unsigned SPR_RAM_DW = 8;
  localparam int unsigned ARB_WAIT_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE       = 2'd0,
    ARB_CPU_ACCESS = 2'd1,
    ARB_CPU_READ   = 2'd2,
    ARB_CPU_DONE   = 2'd3
  } arb_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ARB_WAIT_W-1:0] sat_inc(input logic [ARB_WAIT_W-1:0] v);
    return (v == {ARB_WAIT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sprite_ram_arbiter_if.sv
// CPU-side request bus of the sprite RAM arbiter.
//   cpu_req     request, held by the CPU until cpu_ack
//   cpu_we      1 = write, 0 = read
//   cpu_addr    sprite RAM address
//   cpu_din     write data
//   cpu_dout    read data, held until the next read completes
//   cpu_ack     one-cycle completion pulse
//   cpu_starved wait count has reached the arbiter's STARVE_MAX
// master = CPU side, slave = arbiter side.
interface sprite_ram_arbiter_if;
  import comet_pkg::*;

  logic                  cpu_req;
  logic                  cpu_we;
  logic [SPR_RAM_AW-1:0] cpu_addr;
  logic [SPR_RAM_DW-1:0] cpu_din;
  logic [SPR_RAM_DW-1:0] cpu_dout;
  logic                  cpu_ack;
  logic                  cpu_starved;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    input  cpu_dout, cpu_ack, cpu_starved
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    output cpu_dout, cpu_ack, cpu_starved
  );

endinterface

// File: rtl/sprite_ram_arbiter.sv
// Sprite RAM arbiter: shares one single-port sprite RAM (1-cycle read latency) between
// the sprite engine and the CPU. The engine always has priority and gets a zero-latency
// address pass-through while the arbiter is idle; the CPU is served only while the
// engine is idle.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   eng_busy        engine outside its idle state (blocks CPU grants)
//   eng_addr        engine RAM address
//   eng_dout        RAM read data to the engine (combinational from ram_dout)
//   vblank          vertical blank indicator
//   cpu             CPU request bus (sprite_ram_arbiter_if.slave)
//   ram_addr/ram_we/ram_din/ram_dout   sprite RAM port
//
// Configuration
//   SPRITE_ARB_VBLANK_WRITE_EN  when defined, CPU writes are only granted while
//                               vblank=1; reads are unaffected. Undefined: vblank ignored.
//
// Grant at cycle N: write ack at N+2, read ack at N+3 with cpu_dout valid in that cycle.
module sprite_ram_arbiter
  import comet_pkg::*;
#(
  parameter logic [ARB_WAIT_W-1:0] STARVE_MAX = 16'd1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  eng_busy,
  input  logic [SPR_RAM_AW-1:0] eng_addr,
  output logic [SPR_RAM_DW-1:0] eng_dout,
  input  logic                  vblank,
  sprite_ram_arbiter_if.slave   cpu,
  output logic [SPR_RAM_AW-1:0] ram_addr,
  output logic                  ram_we,
  output logic [SPR_RAM_DW-1:0] ram_din,
  input  logic [SPR_RAM_DW-1:0] ram_dout
);

  arb_state_e            state_q, state_d;
  logic [SPR_RAM_AW-1:0] lat_addr_q, lat_addr_d;
  logic [SPR_RAM_DW-1:0] lat_din_q, lat_din_d;
  logic                  lat_we_q, lat_we_d;
  logic [SPR_RAM_DW-1:0] cpu_dout_q, cpu_dout_d;
  logic                  cpu_ack_q, cpu_ack_d;
  logic [ARB_WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic write_ok;
  logic grant;

`ifdef SPRITE_ARB_VBLANK_WRITE_EN
  // Writes wait for vblank so the engine never sees a half-updated table.
  assign write_ok = !cpu.cpu_we || vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign write_ok      = 1'b1;
`endif

  // The ack gate stops a still-high cpu_req from re-granting in the ack cycle.
  assign grant = (state_q == ARB_IDLE) && cpu.cpu_req && !eng_busy && !cpu_ack_q && write_ok;

  always_comb begin
    state_d    = state_q;
    lat_addr_d = lat_addr_q;
    lat_din_d  = lat_din_q;
    lat_we_d   = lat_we_q;
    cpu_dout_d = cpu_dout_q;
    wait_cnt_d = wait_cnt_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (grant) begin
          lat_addr_d = cpu.cpu_addr;
          lat_din_d  = cpu.cpu_din;
          lat_we_d   = cpu.cpu_we;
          state_d    = ARB_CPU_ACCESS;
        end
      end
      ARB_CPU_ACCESS: state_d = lat_we_q ? ARB_CPU_DONE : ARB_CPU_READ;
      ARB_CPU_READ: begin
        cpu_dout_d = ram_dout;
        state_d    = ARB_CPU_DONE;
      end
      ARB_CPU_DONE: state_d = ARB_IDLE;
      default:      state_d = ARB_IDLE;
    endcase

    // Only a request still waiting in idle counts; one being served is not waiting.
    if (grant) begin
      wait_cnt_d = '0;
    end else if (cpu.cpu_req && (state_q == ARB_IDLE)) begin
      wait_cnt_d = sat_inc(wait_cnt_q);
    end

    cpu_ack_d = (state_d == ARB_CPU_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      lat_addr_q <= '0;
      lat_din_q  <= '0;
      lat_we_q   <= 1'b0;
      cpu_dout_q <= '0;
      cpu_ack_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lat_addr_q <= lat_addr_d;
      lat_din_q  <= lat_din_d;
      lat_we_q   <= lat_we_d;
      cpu_dout_q <= cpu_dout_d;
      cpu_ack_q  <= cpu_ack_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign ram_addr = (state_q == ARB_CPU_ACCESS) ? lat_addr_q : eng_addr;
  assign ram_din  = lat_din_q;
  // Reset masks the strobe in the same cycle so an aborted write never lands.
  assign ram_we   = (state_q == ARB_CPU_ACCESS) && lat_we_q && !reset;
  assign eng_dout = ram_dout;

  assign cpu.cpu_dout    = cpu_dout_q;
  assign cpu.cpu_ack     = cpu_ack_q;
  assign cpu.cpu_starved = (wait_cnt_q >= STARVE_MAX);

endmodule

// File: tb/tb_sprite_ram_arbiter.sv
module tb_sprite_ram_arbiter;
  import comet_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       eng_busy;
  logic [6:0] eng_addr;
  logic [7:0] eng_dout;
  logic       vblank;
  logic [6:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  logic [6:0] unused_ram_addr16;
  logic       unused_ram_we16;
  logic [7:0] unused_ram_din16;
  logic [7:0] unused_eng_dout16;

  always #5 clk = ~clk;

  sprite_ram_arbiter_if cif ();
  sprite_ram_arbiter_if cif16 ();

  assign cif16.cpu_req  = cif.cpu_req;
  assign cif16.cpu_we   = cif.cpu_we;
  assign cif16.cpu_addr = cif.cpu_addr;
  assign cif16.cpu_din  = cif.cpu_din;

  sprite_ram_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .eng_busy (eng_busy),
    .eng_addr (eng_addr),
    .eng_dout (eng_dout),
    .vblank   (vblank),
    .cpu      (cif.slave),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // Twin with a small starvation threshold, driven identically.
  sprite_ram_arbiter #(.STARVE_MAX(16'd16)) dut16 (
    .clk      (clk),
    .reset    (reset),
    .eng_busy (eng_busy),
    .eng_addr (eng_addr),
    .eng_dout (unused_eng_dout16),
    .vblank   (vblank),
    .cpu      (cif16.slave),
    .ram_addr (unused_ram_addr16),
    .ram_we   (unused_ram_we16),
    .ram_din  (unused_ram_din16),
    .ram_dout (ram_dout)
  );

  // Sprite RAM: synchronous, read-first, 1-cycle read latency.
  logic [7:0] mem [128];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Reference model: expected RAM contents.
  logic [7:0] shadow [128];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Full CPU transaction starting at posedge+1 with the arbiter idle and grantable.
  task automatic cpu_op(input logic we, input logic [6:0] a, input logic [7:0] d);
    int   lat;
    logic done;
    cif.cpu_req  = 1'b1;
    cif.cpu_we   = we;
    cif.cpu_addr = a;
    cif.cpu_din  = d;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 50) begin
      smp();
      if (lat == 1) begin
        chk("op_ram_we", ram_we, we);
        chk("op_ram_addr", ram_addr, a);
        if (we) chk("op_ram_din", ram_din, d);
      end
      if (cif.cpu_ack) done = 1'b1;
      else begin
        adv();
        lat++;
      end
    end
    chk(we ? "wr_ack_latency" : "rd_ack_latency", lat, we ? 2 : 3);
    if (we) shadow[a] = d;
    else chk("rd_data", cif.cpu_dout, shadow[a]);
    adv();
    cif.cpu_req = 1'b0;
  endtask

  task automatic eng_reads(input int n);
    logic [6:0] a;
    for (int i = 0; i < n; i++) begin
      a = 7'($urandom_range(127));
      eng_addr = a;
      adv();
      smp();
      chk("eng_rd", eng_dout, shadow[a]);
      adv();
    end
  endtask

  // CPU read held pending for n cycles of eng_busy, then granted once the engine idles.
  task automatic busy_wait(input int n, input logic [6:0] a);
    eng_busy     = 1'b1;
    cif.cpu_req  = 1'b1;
    cif.cpu_we   = 1'b0;
    cif.cpu_addr = a;
    for (int i = 0; i < n; i++) begin
      eng_addr = 7'($urandom_range(127));
      smp();
      chk("busy_no_we", ram_we, 0);
      chk("busy_addr_pass", ram_addr, eng_addr);
      chk("busy_no_ack", cif.cpu_ack, 0);
      chk("busy_starved_1024", cif.cpu_starved, 0);
      chk("busy_starved_16", cif16.cpu_starved, (i >= 16) ? 1 : 0);
      adv();
    end
    eng_busy = 1'b0;
    smp();
    chk("grant_cycle_starved_16", cif16.cpu_starved, (n >= 16) ? 1 : 0);
    adv();
    smp();
    chk("grant_access_addr", ram_addr, a);
    chk("starve_clear_on_grant", cif16.cpu_starved, 0);
    adv();
    adv();
    smp();
    chk("busy_rd_ack", cif.cpu_ack, 1);
    chk("busy_rd_ack16", cif16.cpu_ack, 1);
    chk("busy_rd_data", cif.cpu_dout, shadow[a]);
    chk("busy_rd_data16", cif16.cpu_dout, shadow[a]);
    adv();
    cif.cpu_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] a;
    logic [7:0] d;
    logic [7:0] last_rd;

    reset        = 1'b1;
    eng_busy     = 1'b0;
    eng_addr     = '0;
    vblank       = 1'b0;
    cif.cpu_req  = 1'b0;
    cif.cpu_we   = 1'b0;
    cif.cpu_addr = '0;
    cif.cpu_din  = '0;
    adv();
    adv();
    adv();
    smp();
    chk("rst_ram_we", ram_we, 0);
    adv();
    reset = 1'b0;
    smp();
    chk("rst_ack", cif.cpu_ack, 0);
    chk("rst_dout", cif.cpu_dout, 0);
    chk("rst_starved", cif16.cpu_starved, 0);
    chk("rst_state", dut.state_q, ARB_IDLE);
    adv();

`ifdef SPRITE_ARB_VBLANK_WRITE_EN
    vblank = 1'b1;
`endif
    // Fill the whole RAM through the CPU write path.
    for (int i = 0; i < 128; i++) cpu_op(1'b1, 7'(i), 8'($urandom));

    // Directed write/read of 05 <- A5; cpu_dout holds across a later write.
    cpu_op(1'b1, 7'h05, 8'hA5);
    cpu_op(1'b0, 7'h05, 8'h00);
    chk("rd_05", cif.cpu_dout, 8'hA5);
    cpu_op(1'b1, 7'h06, 8'h3C);
    chk("dout_hold", cif.cpu_dout, 8'hA5);

    // Long engine-busy stall with a pending read, then the 20-cycle starvation run.
    busy_wait(300, 7'h05);
    busy_wait(20, 7'h06);

    // Engine goes busy the cycle after a read grant.
    a = 7'($urandom_range(127));
    cif.cpu_req  = 1'b1;
    cif.cpu_we   = 1'b0;
    cif.cpu_addr = a;
    adv();
    eng_busy = 1'b1;
    smp();
    chk("midtx_access_addr", ram_addr, a);
    chk("midtx_no_we", ram_we, 0);
    adv();
    adv();
    smp();
    chk("midtx_ack", cif.cpu_ack, 1);
    chk("midtx_data", cif.cpu_dout, shadow[a]);
    adv();
    cif.cpu_req = 1'b0;
    adv();
    eng_reads(6);
    eng_busy = 1'b0;

    // Level-sensitive request: req held through ack re-grants in the following cycle.
    cif.cpu_req  = 1'b1;
    cif.cpu_we   = 1'b1;
    cif.cpu_addr = 7'h21;
    cif.cpu_din  = 8'h5A;
    adv();
    smp();
    chk("b2b_first_we", ram_we, 1);
    adv();
    smp();
    chk("b2b_first_ack", cif.cpu_ack, 1);
    shadow[7'h21] = 8'h5A;
    adv();
    cif.cpu_addr = 7'h22;
    cif.cpu_din  = 8'hC3;
    smp();
    chk("b2b_no_ack_regrant", cif.cpu_ack, 0);
    adv();
    smp();
    chk("b2b_second_we", ram_we, 1);
    chk("b2b_second_addr", ram_addr, 7'h22);
    adv();
    smp();
    chk("b2b_second_ack", cif.cpu_ack, 1);
    shadow[7'h22] = 8'hC3;
    adv();
    cif.cpu_req = 1'b0;
    cpu_op(1'b0, 7'h21, 8'h00);
    cpu_op(1'b0, 7'h22, 8'h00);

    // Randomized mix of CPU writes, CPU reads and engine reads.
    for (int i = 0; i < 60; i++) begin
`ifndef SPRITE_ARB_VBLANK_WRITE_EN
      vblank = 1'($urandom);
`endif
      a = 7'($urandom_range(127));
      d = 8'($urandom);
      case ($urandom_range(2))
        0:       cpu_op(1'b1, a, d);
        1:       cpu_op(1'b0, a, d);
        default: eng_reads(1);
      endcase
    end

    // Reset during the access cycle of a write to 10 aborts it.
    cpu_op(1'b0, 7'h11, 8'h00);
    last_rd = cif.cpu_dout;
    d = ~shadow[7'h10];
    cif.cpu_req  = 1'b1;
    cif.cpu_we   = 1'b1;
    cif.cpu_addr = 7'h10;
    cif.cpu_din  = d;
    adv();
    reset = 1'b1;
    smp();
    chk("abort_no_we", ram_we, 0);
    adv();
    reset       = 1'b0;
    cif.cpu_req = 1'b0;
    smp();
    chk("abort_state", dut.state_q, ARB_IDLE);
    chk("abort_dout_cleared", cif.cpu_dout, (last_rd == 8'h00) ? 0 : 0);
    adv();
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("abort_no_ack", cif.cpu_ack, 0);
      adv();
    end
    cpu_op(1'b0, 7'h10, 8'h00);

    // Write-grant policy against vblank.
`ifdef SPRITE_ARB_VBLANK_WRITE_EN
    vblank       = 1'b0;
    cif.cpu_req  = 1'b1;
    cif.cpu_we   = 1'b1;
    cif.cpu_addr = 7'h30;
    cif.cpu_din  = 8'h96;
    for (int i = 0; i < 8; i++) begin
      smp();
      chk("vb_wr_held_we", ram_we, 0);
      chk("vb_wr_held_ack", cif.cpu_ack, 0);
      adv();
    end
    vblank = 1'b1;
    adv();
    smp();
    chk("vb_wr_we", ram_we, 1);
    chk("vb_wr_addr", ram_addr, 7'h30);
    adv();
    smp();
    chk("vb_wr_ack", cif.cpu_ack, 1);
    shadow[7'h30] = 8'h96;
    adv();
    cif.cpu_req = 1'b0;
    vblank = 1'b0;
    cpu_op(1'b0, 7'h30, 8'h00);
    vblank = 1'b1;
`else
    vblank = 1'b0;
    cpu_op(1'b1, 7'h30, 8'h96);
    cpu_op(1'b0, 7'h30, 8'h00);
`endif
    eng_reads(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
